skid_buffer32: RTL and testbench
================================

Name: skid_buffer32

Overview:
- Two-entry elastic pipeline stage with a valid/ready handshake on both sides.
- Sits directly upstream of the 32-bit write-enabled register.
- Downstream transfer (o_valid && i_ready) drives that register's write enable; o_data drives its write data.
- Absorbs one cycle of downstream back-pressure without a combinational ready path from i_ready to o_ready.

Parameters:
DATA_WIDTH, 32, width of the data path in bits.

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  asynchronous reset, active-low (0 = reset asserted)
i_valid  input  1  upstream data valid
o_ready  output  1  stage can accept data this cycle
i_data  input  DATA_WIDTH  upstream data
o_valid  output  1  o_data holds valid data
i_ready  input  1  downstream (register) accepts o_data this cycle
o_data  output  DATA_WIDTH  data toward register i_wr_data
o_count  output  2  occupancy: 0, 1 or 2

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous, active-low. All state clears immediately on i_rst falling, independent of i_clk.
- Reset values:
  - state EMPTY; main and skid data registers 0.
  - o_valid=0, o_ready=1, o_data=0, o_count=0.
- Handshakes:
  - in_fire = i_valid && o_ready.
  - out_fire = o_valid && i_ready.
  - i_data is ignored when in_fire=0.
- Outputs (decoded from registered state only; no combinational i_ready→o_ready or i_valid→o_valid path):
  - o_ready = (state != FULL).
  - o_valid = (state != EMPTY).
  - o_data = main register.
- States (o_count mirrors state: 0/1/2) and transitions:
  - EMPTY: in_fire → ONE, main<=i_data. Otherwise stay.
  - ONE:
    - in_fire && out_fire → ONE, main<=i_data.
    - in_fire only → FULL, skid<=i_data, main unchanged.
    - out_fire only → EMPTY.
    - Neither → stay.
  - FULL: in_fire impossible (o_ready=0). out_fire → ONE, main<=skid. Otherwise stay.
- Latency and throughput:
  - Word accepted at edge N is on o_data with o_valid=1 after edge N.
  - Full throughput of 1 word/cycle while i_ready=1.
- Ordering: strict FIFO; no word dropped or duplicated.
- Stability: while o_valid=1 and i_ready=0, o_data and o_valid hold unchanged.
- Unreachable state encoding (3): next state EMPTY.
- Reset mid-operation: buffered words are discarded. The out_fire in progress that cycle is not guaranteed to reach the register.

Optional Feature:
- Macro: SKID_BUFFER32_FLUSH_EN.
- Defined:
  - Adds port i_flush (input, 1), a synchronous flush.
  - i_flush=1 at an edge: state→EMPTY, main and skid registers →0.
  - Flush takes priority over simultaneous in_fire and out_fire; the incoming word is dropped.
  - o_ready is unaffected by i_flush in the flush cycle.
- Undefined: port i_flush is absent; behaviour is exactly as above.

Test Plan:
- Reset: hold i_rst=0 with i_valid=1, i_data=32'hDEADBEEF → o_valid=0, o_ready=1, o_data=0, o_count=0. Release reset → first accepted word appears the next cycle.
- Streaming: i_ready=1; send 32'h1, 32'h2, 32'h3 on consecutive cycles → o_data shows 1, 2, 3 on consecutive cycles; o_count stays 1; o_ready stays 1.
- Back-pressure: i_ready=0; send 32'hA then 32'hB → o_count=2, o_ready=0, o_data=32'hA held. Raise i_ready → A then B delivered in order, o_count 2→1→0.
- Simultaneous in/out when full: FULL with i_ready=1 and i_valid=1, i_data=32'hC → C not accepted that cycle. Next cycle o_ready=1, C accepted. Output order A, B, C.
- Async reset mid-stream: FULL; pulse i_rst=0 between clock edges → outputs clear without a clock edge; o_valid=0 and o_count=0 immediately.
- Flush (SKID_BUFFER32_FLUSH_EN): FULL with 32'h5, 32'h6; i_flush=1 together with i_valid=1, i_data=32'h7 → next cycle o_count=0, o_valid=0, o_data=0. Word 7 is never output.

Source files
------------

// File: rtl/skid_buffer32.sv
// skid_buffer32: two-entry elastic pipeline stage with valid/ready on both sides.
// Feeds a write-enabled register: o_valid && i_ready is its write enable, o_data its data.
// All outputs decode from registered state only, so i_ready never reaches o_ready
// combinationally.
// Optional feature macro: SKID_BUFFER32_FLUSH_EN adds a synchronous flush input i_flush.
module skid_buffer32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
`ifdef SKID_BUFFER32_FLUSH_EN
    ,
    input  logic                  i_flush
`endif
);

    // Occupancy-coded states: the encoding doubles as the o_count value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;

    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] w_next_main;
    logic [DATA_WIDTH-1:0] w_next_skid;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_flush;

`ifdef SKID_BUFFER32_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Output decode purely from registered state.
    always_comb begin
        o_ready = (r_state != ST_FULL);
        o_valid = (r_state != ST_EMPTY);
        o_data  = r_main;
        o_count = r_state;
    end

    // Next-state and data-path selection; flush overrides any handshake.
    always_comb begin
        w_in_fire    = i_valid && o_ready;
        w_out_fire   = o_valid && i_ready;
        w_next_state = r_state;
        w_next_main  = r_main;
        w_next_skid  = r_skid;
        if (w_flush) begin
            w_next_state = ST_EMPTY;
            w_next_main  = {DATA_WIDTH{1'b0}};
            w_next_skid  = {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_next_state = ST_ONE;
                        w_next_main  = i_data;
                    end else begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // Pass-through: the new word replaces the departing one.
                        w_next_state = ST_ONE;
                        w_next_main  = i_data;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new word in the skid slot.
                        w_next_state = ST_FULL;
                        w_next_skid  = i_data;
                    end else if (w_out_fire) begin
                        w_next_state = ST_EMPTY;
                    end else begin
                        w_next_state = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // o_ready is low here, so only a departure can occur.
                    if (w_out_fire) begin
                        w_next_state = ST_ONE;
                        w_next_main  = r_skid;
                    end else begin
                        w_next_state = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding recovers to empty.
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers with asynchronous active-low clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_EMPTY;
            r_main  <= {DATA_WIDTH{1'b0}};
            r_skid  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_main  <= w_next_main;
            r_skid  <= w_next_skid;
        end
    end

endmodule

// File: tb/tb_skid_buffer32.sv
// Self-checking bench for skid_buffer32: directed scenarios plus random traffic
// compared against a queue-based model of a two-deep FIFO.
module tb_skid_buffer32;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_count;
`ifdef SKID_BUFFER32_FLUSH_EN
    logic        i_flush;
`endif

    int n_cmp;
    int n_err;

    logic [31:0] mq[$];      // model contents, head = word on o_data
    logic [31:0] dut_log[$]; // words the DUT actually handed downstream

    skid_buffer32 #(.DATA_WIDTH(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
`ifdef SKID_BUFFER32_FLUSH_EN
        ,
        .i_flush (i_flush)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One clock: log DUT transfers, advance the model, return at the next negedge.
    task automatic cyc();
        bit inf;
        bit outf;
        bit fl;
        inf = i_valid && (mq.size() < 2);
        outf = (mq.size() > 0) && i_ready;
        fl = 1'b0;
`ifdef SKID_BUFFER32_FLUSH_EN
        fl = i_flush;
`endif
        if (o_valid && i_ready) dut_log.push_back(o_data);
        @(posedge i_clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(i_data);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_valid = 1'b1; i_data = 32'hDEADBEEF; i_ready = 1'b0;
        mq.delete();
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", o_ready); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL rst_data got %h want 0", o_data); end
        n_cmp++; if (o_count !== 2'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", o_count); end
        i_rst = 1'b1; i_data = 32'h11;
        cyc();
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h11) begin n_err++; $display("FAIL rst_first got v=%0b d=%h want v=1 d=00000011", o_valid, o_data); end
        i_valid = 1'b0; i_ready = 1'b1;
        cyc();
        n_cmp++; if (o_count !== 2'd0) begin n_err++; $display("FAIL rst_drain got %0d want 0", o_count); end
        dut_log.delete();
    endtask

    task automatic test_streaming();
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            i_valid = 1'b1; i_data = k;
            cyc();
            n_cmp++; if (o_data !== k || o_valid !== 1'b1) begin n_err++; $display("FAIL stream_data%0d got %h want %h", k, o_data, k); end
            n_cmp++; if (o_count !== 2'd1 || o_ready !== 1'b1) begin n_err++; $display("FAIL stream_occ%0d got c=%0d r=%0b want c=1 r=1", k, o_count, o_ready); end
        end
        i_valid = 1'b0;
        cyc();
        n_cmp++; if (o_count !== 2'd0) begin n_err++; $display("FAIL stream_end got %0d want 0", o_count); end
        n_cmp++; if (dut_log.size() != 3 || dut_log[0] !== 32'h1 || dut_log[2] !== 32'h3) begin n_err++; $display("FAIL stream_order got n=%0d want 3 words 1..3", dut_log.size()); end
        dut_log.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hC;
        // Fill with A, B while stalled, then drain.
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA; cyc();
        i_data = 32'hB; cyc();
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (o_count !== 2'd2 || o_ready !== 1'b0 || o_data !== 32'hA) begin n_err++; $display("FAIL bp_hold%0d got c=%0d r=%0b d=%h want c=2 r=0 d=0000000a", k, o_count, o_ready, o_data); end
            cyc();
        end
        i_ready = 1'b1; cyc();
        n_cmp++; if (o_count !== 2'd1 || o_data !== 32'hB) begin n_err++; $display("FAIL bp_drain1 got c=%0d d=%h want c=1 d=0000000b", o_count, o_data); end
        cyc();
        n_cmp++; if (o_count !== 2'd0 || o_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain0 got c=%0d v=%0b want c=0 v=0", o_count, o_valid); end
        n_cmp++; if (dut_log.size() != 2 || dut_log[0] !== 32'hA || dut_log[1] !== 32'hB) begin n_err++; $display("FAIL bp_order got n=%0d want A,B", dut_log.size()); end
        dut_log.delete();
        // Full, then offer C with i_ready=1: C must wait one cycle.
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA; cyc();
        i_data = 32'hB; cyc();
        i_ready = 1'b1; i_data = 32'hC; cyc();
        n_cmp++; if (o_count !== 2'd1 || o_data !== 32'hB || o_ready !== 1'b1) begin n_err++; $display("FAIL full_sim got c=%0d d=%h r=%0b want c=1 d=0000000b r=1", o_count, o_data, o_ready); end
        cyc();
        n_cmp++; if (o_count !== 2'd1 || o_data !== 32'hC) begin n_err++; $display("FAIL full_acceptC got c=%0d d=%h want c=1 d=0000000c", o_count, o_data); end
        i_valid = 1'b0; cyc();
        n_cmp++; if (dut_log.size() != 3) begin n_err++; $display("FAIL full_count got %0d want 3", dut_log.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (dut_log[k] !== exp_w[k]) begin n_err++; $display("FAIL full_order%0d got %h want %h", k, dut_log[k], exp_w[k]); end
            end
        end
        dut_log.delete();
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h21; cyc();
        i_data = 32'h22; cyc();
        i_valid = 1'b0;
        n_cmp++; if (o_count !== 2'd2) begin n_err++; $display("FAIL ar_full got %0d want 2", o_count); end
        #2 i_rst = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin n_err++; $display("FAIL ar_clear got v=%0b c=%0d want v=0 c=0", o_valid, o_count); end
        n_cmp++; if (o_ready !== 1'b1 || o_data !== 32'h0) begin n_err++; $display("FAIL ar_outs got r=%0b d=%h want r=1 d=0", o_ready, o_data); end
        mq.delete();
        @(negedge i_clk);
        i_rst = 1'b1;
        dut_log.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_data  = $urandom;
            n_cmp++; if (o_count !== mq.size() || o_valid !== (mq.size() > 0) || o_ready !== (mq.size() < 2)) begin
                n_err++; $display("FAIL rnd_occ@%0d got c=%0d v=%0b r=%0b want c=%0d", n, o_count, o_valid, o_ready, mq.size());
            end
            if (mq.size() > 0) begin
                n_cmp++; if (o_data !== mq[0]) begin n_err++; $display("FAIL rnd_data@%0d got %h want %h", n, o_data, mq[0]); end
            end
            cyc();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (o_count !== 2'd0) begin n_err++; $display("FAIL rnd_drain got %0d want 0", o_count); end
        dut_log.delete();
    endtask

`ifdef SKID_BUFFER32_FLUSH_EN
    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h5; cyc();
        i_data = 32'h6; cyc();
        i_data = 32'h7; i_flush = 1'b1;
        n_cmp++; if (o_ready !== 1'b0 || o_count !== 2'd2) begin n_err++; $display("FAIL fl_pre got r=%0b c=%0d want r=0 c=2", o_ready, o_count); end
        cyc();
        i_flush = 1'b0; i_valid = 1'b0;
        n_cmp++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_data !== 32'h0) begin n_err++; $display("FAIL fl_clear got c=%0d v=%0b d=%h want 0 0 0", o_count, o_valid, o_data); end
        i_ready = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (dut_log.size() != 0) begin n_err++; $display("FAIL fl_no7 got %0d words want 0", dut_log.size()); end
        // Flush with one word while a new word arrives and downstream accepts.
        i_valid = 1'b1; i_data = 32'h8; cyc();
        i_data = 32'h9; i_flush = 1'b1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready got %0b want 1", o_ready); end
        cyc();
        i_flush = 1'b0; i_valid = 1'b0;
        n_cmp++; if (o_count !== 2'd0 || o_valid !== 1'b0) begin n_err++; $display("FAIL fl_one got c=%0d v=%0b want 0 0", o_count, o_valid); end
        dut_log.delete();
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0;
        i_valid = 1'b0; i_ready = 1'b0; i_data = 32'h0; i_rst = 1'b0;
`ifdef SKID_BUFFER32_FLUSH_EN
        i_flush = 1'b0;
`endif
        test_reset();
        test_streaming();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef SKID_BUFFER32_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
